// File: rtl/aibnd_sig_filt_pkg.sv
// Shared types and defaults for the AIB sideband signal synchronizer/filter.
// State encoding puts the output level in bit 1 and the qualifying flag in bit 0.
package aibnd_sig_filt_pkg;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILT_CNT_W  = 4;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    RISE_QUAL = 2'b01,
    HIGH      = 2'b10,
    FALL_QUAL = 2'b11
  } filt_state_e;

endpackage

// File: rtl/aibnd_sync_chain.sv
// Multi-flop level synchronizer for an asynchronous single-bit input.
// Reusable by any sideband receiver; resets to 0.
module aibnd_sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/aibnd_sig_sync_filter.sv
// Synchronizes the buffer's sig_out level, qualifies transitions over filt_len
// cycles, and emits registered single-cycle rise/fall events.
module aibnd_sig_sync_filter
  import aibnd_sig_filt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_CNT_W  = DEF_FILT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sig_in,
  input  logic                  filt_en,
  input  logic [FILT_CNT_W-1:0] filt_len,
  input  logic                  vccl_aibnd,
  input  logic                  vssl_aibnd,
  output logic                  sig_out,
  output logic                  sig_rise,
  output logic                  sig_fall,
  output logic                  sig_busy
);

  filt_state_e           state_q, state_d;
  logic [FILT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  s;
  logic                  bypass;
  logic                  qual_done;
  logic [FILT_CNT_W-1:0] cnt_inc;
  logic                  unused_supply;

  // Supply pins exist only for netlist consistency with the analog buffer.
  assign unused_supply = vccl_aibnd ^ vssl_aibnd;

  aibnd_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sig_in),
    .q_o   (s)
  );

  assign bypass    = !filt_en || (filt_len == '0);
  // >= rather than == so a live reduction of filt_len ends qualification at once.
  assign qual_done = !filt_en || (cnt_q >= filt_len);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + FILT_CNT_W'(1);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s) begin
          if (bypass) begin
            state_d = HIGH;
            rise_d  = 1'b1;
          end else begin
            state_d = RISE_QUAL;
            cnt_d   = FILT_CNT_W'(1);
          end
        end
      end
      RISE_QUAL: begin
        if (!s) begin
          state_d = LOW;
        end else if (qual_done) begin
          state_d = HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HIGH: begin
        if (!s) begin
          if (bypass) begin
            state_d = LOW;
            fall_d  = 1'b1;
          end else begin
            state_d = FALL_QUAL;
            cnt_d   = FILT_CNT_W'(1);
          end
        end
      end
      FALL_QUAL: begin
        if (s) begin
          state_d = HIGH;
        end else if (qual_done) begin
          state_d = LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = LOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sig_out  = (state_q == HIGH) || (state_q == FALL_QUAL);
  assign sig_busy = (state_q == RISE_QUAL) || (state_q == FALL_QUAL);
  assign sig_rise = rise_q;
  assign sig_fall = fall_q;

endmodule

// File: tb/tb_aibnd_sig_sync_filter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a run-length reference model.
module tb_aibnd_sig_sync_filter;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FILT_CNT_W  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  sig_in;
  logic                  filt_en;
  logic [FILT_CNT_W-1:0] filt_len;
  logic                  vccl_aibnd = 1'b1;
  logic                  vssl_aibnd = 1'b0;
  logic                  sig_out, sig_rise, sig_fall, sig_busy;

  int total = 0;
  int bad   = 0;

  // Reference model: the synchronizer is a pure SYNC_STAGES-edge delay; the
  // output flips once the delayed input has disagreed with it for len+1 edges.
  logic out_m  = 1'b0;
  logic rise_m = 1'b0;
  logic fall_m = 1'b0;
  logic busy_m = 1'b0;
  int   run_m  = 0;
  logic hist_m [SYNC_STAGES];

  aibnd_sig_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CNT_W  (FILT_CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .filt_en    (filt_en),
    .filt_len   (filt_len),
    .vccl_aibnd (vccl_aibnd),
    .vssl_aibnd (vssl_aibnd),
    .sig_out    (sig_out),
    .sig_rise   (sig_rise),
    .sig_fall   (sig_fall),
    .sig_busy   (sig_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    out_m  = 1'b0;
    rise_m = 1'b0;
    fall_m = 1'b0;
    busy_m = 1'b0;
    run_m  = 0;
    for (int i = 0; i < SYNC_STAGES; i++) hist_m[i] = 1'b0;
  endtask

  task automatic model_step();
    logic s;
    s = hist_m[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
    hist_m[0] = sig_in;
    rise_m = 1'b0;
    fall_m = 1'b0;
    if (s != out_m) begin
      run_m++;
      if (!filt_en || run_m > int'(filt_len)) begin
        out_m  = s;
        rise_m = s;
        fall_m = !s;
        run_m  = 0;
      end
    end else begin
      run_m = 0;
    end
    busy_m = (run_m != 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison of DUT against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("cmp_out",  sig_out,  out_m);
        check("cmp_rise", sig_rise, rise_m);
        check("cmp_fall", sig_fall, fall_m);
        check("cmp_busy", sig_busy, busy_m);
        check("cmp_excl", sig_rise & sig_fall, 1'b0);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic expect_all(input string tag, input logic o, input logic r,
                            input logic f, input logic b);
    check({tag, ".out"},  sig_out,  o);
    check({tag, ".rise"}, sig_rise, r);
    check({tag, ".fall"}, sig_fall, f);
    check({tag, ".busy"}, sig_busy, b);
    check({tag, ".m_out"},  out_m,  o);
    check({tag, ".m_rise"}, rise_m, r);
    check({tag, ".m_busy"}, busy_m, b);
  endtask

  initial begin
    int   hold;
    logic lvl;

    rst_n    = 1'b0;
    sig_in   = 1'b0;
    filt_en  = 1'b0;
    filt_len = 4'd4;
    #1;
    expect_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(2);
    expect_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Bypass: capture edge k, output and pulse after k+2, pulse gone after k+3.
    sig_in = 1'b1;
    step(2);
    expect_all("byp_k1", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    expect_all("byp_k2", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    expect_all("byp_k3", 1'b1, 1'b0, 1'b0, 1'b0);
    sig_in = 1'b0;
    step(4);
    check("byp_back_low", sig_out, 1'b0);

    // Filter pass with N=4: busy after k+2..k+5, rise after k+6.
    filt_en  = 1'b1;
    filt_len = 4'd4;
    sig_in   = 1'b1;
    step(2);
    expect_all("fp_k1", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 2; j <= 5; j++) begin
      step(1);
      expect_all($sformatf("fp_k%0d", j), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step(1);
    expect_all("fp_k6", 1'b1, 1'b1, 1'b0, 1'b0);
    step(13);
    check("fp_hold", sig_out, 1'b1);
    sig_in = 1'b0;
    step(8);
    expect_all("fp_low", 1'b0, 1'b0, 1'b0, 1'b0);

    // Glitch of 3 cycles with N=4 is rejected.
    sig_in = 1'b1;
    step(3);
    sig_in = 1'b0;
    expect_all("gl_k2", 1'b0, 1'b0, 1'b0, 1'b1);
    step(2);
    expect_all("gl_k4", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    expect_all("gl_k5", 1'b0, 1'b0, 1'b0, 1'b0);

    // Fall qualification with N=8, shortened to 3 once cnt reaches 5.
    filt_len = 4'd8;
    sig_in   = 1'b1;
    step(12);
    check("fq_high", sig_out, 1'b1);
    sig_in = 1'b0;
    step(7);
    expect_all("fq_k6", 1'b1, 1'b0, 1'b0, 1'b1);
    filt_len = 4'd3;
    step(1);
    expect_all("fq_k7", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    expect_all("fq_k8", 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation: N=15 exits at cnt=15, then stays high with no retrigger.
    filt_len = 4'd15;
    sig_in   = 1'b1;
    step(17);
    expect_all("sat_k16", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    expect_all("sat_k17", 1'b1, 1'b1, 1'b0, 1'b0);
    step(10);
    expect_all("sat_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    filt_en = 1'b0;
    sig_in  = 1'b0;
    step(3);
    expect_all("sat_fall", 1'b0, 1'b0, 1'b1, 1'b0);

    // Async reset in the middle of RISE_QUAL.
    filt_en  = 1'b1;
    filt_len = 4'd4;
    sig_in   = 1'b1;
    step(4);
    expect_all("rq_before", 1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rq_rst.out",  sig_out,  1'b0);
    check("rq_rst.rise", sig_rise, 1'b0);
    check("rq_rst.fall", sig_fall, 1'b0);
    check("rq_rst.busy", sig_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    expect_all("rq_rel1", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    expect_all("rq_rel2", 1'b0, 1'b0, 1'b0, 1'b0);
    sig_in = 1'b0;
    step(6);

    // Randomized levels, run lengths and configuration; the model checks each cycle.
    lvl  = 1'b0;
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        lvl  = ~lvl;
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 24))
                                           : int'($urandom_range(1, 8));
      end
      hold--;
      sig_in = lvl;
      if ($urandom_range(0, 99) == 0)  filt_len = FILT_CNT_W'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) filt_en  = ($urandom_range(0, 3) != 0);
      step(1);
    end

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
